// File: rtl/transform_pkg.sv
// Shared transform package: sequencer state encodings, block-type codes,
// butterfly-latency limits and residual_state codes used by the transform
// datapath blocks.
package transform_pkg;

    // Sequencer states; the encoding must fit a 3-bit state register.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALL0   = 3'd1,
        ST_IQ     = 3'd2,
        ST_DHT_R  = 3'd3,
        ST_DHT_C  = 3'd4,
        ST_IDCT_R = 3'd5,
        ST_IDCT_C = 3'd6,
        ST_DONE   = 3'd7
    } tseq_state_t;

    // Block type codes presented on blk_type.
    localparam logic [1:0] BLK_LUMA_4X4  = 2'd0;
    localparam logic [1:0] BLK_I16_DC    = 2'd1;
    localparam logic [1:0] BLK_CHROMA_DC = 2'd2;
    localparam logic [1:0] BLK_RESERVED  = 2'd3;

    // Legal range for the per-stage butterfly latency (stage counter is 2 bits).
    localparam int BF_LAT_MIN = 1;
    localparam int BF_LAT_MAX = 4;

    // Residual decode progress codes shared with the residual block.
    typedef enum logic [1:0] {
        RES_IDLE    = 2'd0,
        RES_DC      = 2'd1,
        RES_AC      = 2'd2,
        RES_DONE    = 2'd3
    } residual_state_t;

    // DC blocks (Intra16x16 luma DC and chroma DC) start with a Hadamard pass.
    function automatic logic is_dc_type(input logic [1:0] bt);
        return (bt == BLK_I16_DC) || (bt == BLK_CHROMA_DC);
    endfunction

    // First stage entered after a block is accepted. Reserved type behaves as
    // a 4x4 residual. The skip flag is only meaningful for non-DC blocks.
    function automatic tseq_state_t first_stage(input logic [1:0] bt,
                                                input logic       skip);
        tseq_state_t st;
        if (is_dc_type(bt)) begin
            st = ST_DHT_R;
        end else if (skip) begin
            st = ST_ALL0;
        end else begin
            st = ST_IQ;
        end
        return st;
    endfunction

endpackage

// File: rtl/transform_seq.sv
// Transform sequencer: steps one block through inverse quantisation,
// Hadamard (DHT) and IDCT passes, issuing one-cycle write strobes to the
// transform register file in the last cycle of each stage.
// Optional feature macro: TRANSFORM_SEQ_ALL0_SKIP_EN -- when defined, 4x4
// blocks flagged with no AC coefficients take the short ALL0 -> DONE path.
module transform_seq
    import transform_pkg::*;
#(
    parameter int BF_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] blk_type,
    input  logic       ac_all_0,
    output logic       busy,
    output logic       done,
    output logic       col_mode,
    output logic       ac_all_0_wr,
    output logic       iq_wr,
    output logic       dht_wr,
    output logic       idct_wr
);

    // Out-of-range latencies are clamped so the 2-bit counter stays consistent.
    localparam int BF_LAT_C = (BF_LAT < BF_LAT_MIN) ? BF_LAT_MIN :
                              (BF_LAT > BF_LAT_MAX) ? BF_LAT_MAX : BF_LAT;
    localparam logic [1:0] LAST_CNT = 2'(BF_LAT_C - 1);

    tseq_state_t r_state;
    tseq_state_t w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic [1:0]  r_blk_type;
    logic        w_accept;
    logic        w_skip_req;
    logic        w_bf_last;
    logic        w_act;

    // A stall freezes everything; clr only acts on an enabled cycle.
    assign w_act     = ena && !clr;
    assign w_accept  = ena && !clr && start && (r_state == ST_IDLE);
    assign w_bf_last = (r_cnt == LAST_CNT);

`ifdef TRANSFORM_SEQ_ALL0_SKIP_EN
    logic r_ac_all_0;

    assign w_skip_req = ac_all_0;

    // Capture the zero-AC flag alongside the block type at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac_all_0 <= 1'b0;
        end else if (w_accept) begin
            r_ac_all_0 <= ac_all_0;
        end
    end
`else
    logic w_unused_ac;

    // Shortcut disabled: the zero-AC flag never influences sequencing.
    assign w_skip_req  = 1'b0;
    assign w_unused_ac = ac_all_0;
`endif

    // State, stage counter and latched block type.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_blk_type <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_blk_type <= blk_type;
            end
        end
    end

    // Next-state and counter: butterfly stages hold for BF_LAT cycles, the
    // counter restarts at 0 whenever a new stage is entered.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!ena) begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
        end else if (clr) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_next = 2'd0;
                    if (start) begin
                        w_state_next = first_stage(blk_type,
                                                   w_skip_req && !is_dc_type(blk_type));
                    end
                end
                ST_ALL0: begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = 2'd0;
                end
                ST_IQ: begin
                    // DC blocks finish with IQ; 4x4 blocks go on to the IDCT.
                    w_state_next = is_dc_type(r_blk_type) ? ST_DONE : ST_IDCT_R;
                    w_cnt_next   = 2'd0;
                end
                ST_DHT_R: begin
                    if (w_bf_last) begin
                        // Chroma DC is a 2x2 transform: no column pass.
                        w_state_next = (r_blk_type == BLK_I16_DC) ? ST_DHT_C : ST_IQ;
                        w_cnt_next   = 2'd0;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
                ST_DHT_C: begin
                    if (w_bf_last) begin
                        w_state_next = ST_IQ;
                        w_cnt_next   = 2'd0;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
                ST_IDCT_R: begin
                    if (w_bf_last) begin
                        w_state_next = ST_IDCT_C;
                        w_cnt_next   = 2'd0;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
                ST_IDCT_C: begin
                    if (w_bf_last) begin
                        w_state_next = ST_DONE;
                        w_cnt_next   = 2'd0;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    // A start seen here is deliberately dropped.
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 2'd0;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // Moore output decode; strobes fire only in the final cycle of a stage,
    // and are suppressed on stalled or aborted cycles.
    always_comb begin
        busy     = (r_state != ST_IDLE);
        col_mode = (r_state == ST_DHT_C) || (r_state == ST_IDCT_C);
        done     = w_act && (r_state == ST_DONE);
        iq_wr    = w_act && (r_state == ST_IQ);
        dht_wr   = w_act && w_bf_last &&
                   ((r_state == ST_DHT_R) || (r_state == ST_DHT_C));
        idct_wr  = w_act && w_bf_last &&
                   ((r_state == ST_IDCT_R) || (r_state == ST_IDCT_C));
`ifdef TRANSFORM_SEQ_ALL0_SKIP_EN
        ac_all_0_wr = w_act && r_ac_all_0 && (r_state == ST_ALL0);
`else
        ac_all_0_wr = 1'b0;
`endif
    end

endmodule

// File: tb/tb_transform_seq.sv
// Directed testbench for transform_seq. Two instances (BF_LAT=1 and 3) share
// all inputs; each scenario first aborts both to IDLE with clr. Output vector
// bit order: {busy, done, col_mode, ac_all_0_wr, iq_wr, dht_wr, idct_wr}.
// Expectations follow TRANSFORM_SEQ_ALL0_SKIP_EN when it is defined.
module tb_transform_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       start;
    logic [1:0] blk_type;
    logic       ac_all_0;

    logic d1_busy, d1_done, d1_col, d1_a0wr, d1_iqwr, d1_dhtwr, d1_idctwr;
    logic d3_busy, d3_done, d3_col, d3_a0wr, d3_iqwr, d3_dhtwr, d3_idctwr;
    logic [6:0] d1_vec;
    logic [6:0] d3_vec;

    int n_checks;
    int n_fail;

    assign d1_vec = {d1_busy, d1_done, d1_col, d1_a0wr, d1_iqwr, d1_dhtwr, d1_idctwr};
    assign d3_vec = {d3_busy, d3_done, d3_col, d3_a0wr, d3_iqwr, d3_dhtwr, d3_idctwr};

    transform_seq #(.BF_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .start(start),
        .blk_type(blk_type), .ac_all_0(ac_all_0),
        .busy(d1_busy), .done(d1_done), .col_mode(d1_col),
        .ac_all_0_wr(d1_a0wr), .iq_wr(d1_iqwr), .dht_wr(d1_dhtwr), .idct_wr(d1_idctwr)
    );

    transform_seq #(.BF_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .start(start),
        .blk_type(blk_type), .ac_all_0(ac_all_0),
        .busy(d3_busy), .done(d3_done), .col_mode(d3_col),
        .ac_all_0_wr(d3_a0wr), .iq_wr(d3_iqwr), .dht_wr(d3_dhtwr), .idct_wr(d3_idctwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Abort both instances to IDLE; returns just after the edge (cycle 0).
    task automatic sync_idle;
        ena   = 1'b1;
        start = 1'b0;
        clr   = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        ena      = 1'b1;
        clr      = 1'b0;
        start    = 1'b1;
        blk_type = 2'd0;
        ac_all_0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (d1_vec !== 7'b0) begin
                $display("FAIL reset_d1 cycle %0d: got %b expected %b", c, d1_vec, 7'b0);
                n_fail++;
            end
            n_checks++;
            if (d3_vec !== 7'b0) begin
                $display("FAIL reset_d3 cycle %0d: got %b expected %b", c, d3_vec, 7'b0);
                n_fail++;
            end
            n_checks++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        $display("reset: outputs held low during reset");
    endtask

    task automatic test_type0_full;
        logic [6:0] exp_v [0:5];
        exp_v = '{7'b0000000, 7'b1000100, 7'b1000001, 7'b1010001, 7'b1100000, 7'b0000000};
        sync_idle();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            start    = (c == 0);
            blk_type = 2'd0;
            ac_all_0 = 1'b0;
            #1;
            if (d1_vec !== exp_v[c]) begin
                $display("FAIL type0_full cycle %0d: got %b expected %b", c, d1_vec, exp_v[c]);
                n_fail++;
            end
            n_checks++;
        end
        $display("type0_full: sequence IQ/IDCT_R/IDCT_C/DONE checked");
    endtask

    task automatic test_type3;
        logic [6:0] exp_v [0:5];
        exp_v = '{7'b0000000, 7'b1000100, 7'b1000001, 7'b1010001, 7'b1100000, 7'b0000000};
        sync_idle();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            start    = (c == 0);
            blk_type = 2'd3;
            ac_all_0 = 1'b0;
            #1;
            if (d1_vec !== exp_v[c]) begin
                $display("FAIL type3 cycle %0d: got %b expected %b", c, d1_vec, exp_v[c]);
                n_fail++;
            end
            n_checks++;
        end
        $display("type3: follows type0 sequence checked");
    endtask

    task automatic test_all0;
        logic [6:0] exp_v [0:5];
`ifdef TRANSFORM_SEQ_ALL0_SKIP_EN
        exp_v = '{7'b0000000, 7'b1001000, 7'b1100000, 7'b0000000, 7'b0000000, 7'b0000000};
`else
        exp_v = '{7'b0000000, 7'b1000100, 7'b1000001, 7'b1010001, 7'b1100000, 7'b0000000};
`endif
        sync_idle();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            start    = (c == 0);
            blk_type = 2'd0;
            ac_all_0 = (c == 0);
            #1;
            if (d1_vec !== exp_v[c]) begin
                $display("FAIL all0 cycle %0d: got %b expected %b", c, d1_vec, exp_v[c]);
                n_fail++;
            end
            n_checks++;
        end
        $display("all0: zero-AC block checked");
    endtask

    task automatic test_type1;
        logic [6:0] exp1 [0:9];
        logic [6:0] exp3 [0:9];
        exp1 = '{7'b0000000, 7'b1000010, 7'b1010010, 7'b1000100, 7'b1100000,
                 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
        exp3 = '{7'b0000000, 7'b1000000, 7'b1000000, 7'b1000010, 7'b1010000,
                 7'b1010000, 7'b1010010, 7'b1000100, 7'b1100000, 7'b0000000};
        sync_idle();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            start    = (c == 0);
            blk_type = 2'd1;
            ac_all_0 = 1'b1;
            #1;
            if (d1_vec !== exp1[c]) begin
                $display("FAIL type1_lat1 cycle %0d: got %b expected %b", c, d1_vec, exp1[c]);
                n_fail++;
            end
            n_checks++;
            if (d3_vec !== exp3[c]) begin
                $display("FAIL type1_lat3 cycle %0d: got %b expected %b", c, d3_vec, exp3[c]);
                n_fail++;
            end
            n_checks++;
        end
        $display("type1: DHT_R/DHT_C/IQ/DONE checked at BF_LAT 1 and 3");
    endtask

    task automatic test_type2_stall;
        logic [6:0] exp_v [0:5];
        exp_v = '{7'b0000000, 7'b1000000, 7'b1000010, 7'b1000100, 7'b1100000, 7'b0000000};
        sync_idle();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            start    = (c == 0);
            blk_type = 2'd2;
            ac_all_0 = 1'b0;
            ena      = (c != 1);
            #1;
            if (d1_vec !== exp_v[c]) begin
                $display("FAIL type2_stall cycle %0d: got %b expected %b", c, d1_vec, exp_v[c]);
                n_fail++;
            end
            n_checks++;
        end
        ena = 1'b1;
        $display("type2_stall: ena low freezes and resumes checked");
    endtask

    task automatic test_clr_abort;
        logic [6:0] exp_v [0:8];
        exp_v = '{7'b0000000, 7'b1000100, 7'b1000000, 7'b0000000, 7'b1000100,
                  7'b1000001, 7'b1010001, 7'b1100000, 7'b0000000};
        sync_idle();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            start    = (c <= 3);
            clr      = (c == 2);
            blk_type = 2'd0;
            ac_all_0 = 1'b0;
            #1;
            if (d1_vec !== exp_v[c]) begin
                $display("FAIL clr_abort cycle %0d: got %b expected %b", c, d1_vec, exp_v[c]);
                n_fail++;
            end
            n_checks++;
        end
        clr = 1'b0;
        $display("clr_abort: abort and re-accept checked");
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_v [0:5];
        exp_v = '{7'b0000000, 7'b1000010, 7'b1000100, 7'b1100000, 7'b0000000, 7'b1000010};
        sync_idle();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            start    = 1'b1;
            blk_type = 2'd2;
            ac_all_0 = 1'b0;
            #1;
            if (d1_vec !== exp_v[c]) begin
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, d1_vec, exp_v[c]);
                n_fail++;
            end
            n_checks++;
        end
        start = 1'b0;
        $display("back_to_back: start while busy/DONE dropped checked");
    endtask

    task automatic test_reset_midblock;
        sync_idle();
        start    = 1'b1;
        blk_type = 2'd0;
        ac_all_0 = 1'b0;
        step();
        start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        if (d1_vec !== 7'b0) begin
            $display("FAIL reset_mid_async: got %b expected %b", d1_vec, 7'b0);
            n_fail++;
        end
        n_checks++;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (d1_vec !== 7'b0) begin
                $display("FAIL reset_mid_after cycle %0d: got %b expected %b", c, d1_vec, 7'b0);
                n_fail++;
            end
            n_checks++;
        end
        $display("reset_midblock: block aborted without done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        clr      = 1'b0;
        start    = 1'b0;
        blk_type = 2'd0;
        ac_all_0 = 1'b0;
        test_reset();
        test_type0_full();
        test_type3();
        test_all0();
        test_type1();
        test_type2_stall();
        test_clr_abort();
        test_back_to_back();
        test_reset_midblock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
